// File: rtl/silife_spi_ctrl.sv
// silife_spi_ctrl
// ---------------
// SPI mode-0 control slave for the Game-of-Life user project. The external
// SPI pins are oversampled by the system clock. Each transaction is turned
// into single-cycle read/write strobes toward the grid/display register file.
//
// Transaction format (cs low for the whole transaction):
//   byte 0      : command, bit7 = 1 write / 0 read, bits6:0 = start address
//   bytes 1..N  : data; the address auto-increments modulo 128 per byte
//
// Register-file interface protocol (this block is always the initiator):
//   reg_we : one-cycle strobe. reg_addr and reg_wdata are valid in that
//            cycle. reg_addr increments on the following cycle.
//   reg_re : one-cycle strobe. reg_addr is valid in that cycle.
//            reg_rdata must be valid on the next cycle and is captured then.
//   There is no back-pressure. reg_we and reg_re are never high together.
//
// Ports:
//   clock, resetb          system clock (rising edge), async active-low reset
//   spi_cs/sck/din         SPI pins, asynchronous to clock
//   spi_dout, spi_dout_oe  MISO and its pad output enable
//   reg_addr/wdata/we/re   register-file request side
//   reg_rdata              register-file read data
//
// The FSM state is held in state_q so that checkers can observe it.
module silife_spi_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       resetb,
  input  logic       spi_cs,
  input  logic       spi_sck,
  input  logic       spi_din,
  output logic       spi_dout,
  output logic       spi_dout_oe,
  output logic [6:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata
);

  // A synchronizer needs at least two flops.
  localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_WRITE = 2'd2,
    ST_READ  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // ---------------------------------------------------------------------------
  // Input synchronizers and sck edge detection
  // ---------------------------------------------------------------------------
  logic [NS-1:0] cs_sync;
  logic [NS-1:0] sck_sync;
  logic [NS-1:0] din_sync;
  logic          sck_prev;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      cs_sync  <= '1;
      sck_sync <= '0;
      din_sync <= '0;
      sck_prev <= 1'b0;
    end else begin
      cs_sync  <= {cs_sync[NS-2:0], spi_cs};
      sck_sync <= {sck_sync[NS-2:0], spi_sck};
      din_sync <= {din_sync[NS-2:0], spi_din};
      sck_prev <= sck_sync[NS-1];
    end
  end

  logic cs_s, sck_s, din_s;
  logic sck_rise, sck_fall;

  assign cs_s     = cs_sync[NS-1];
  assign sck_s    = sck_sync[NS-1];
  assign din_s    = din_sync[NS-1];
  assign sck_rise = sck_s & ~sck_prev;
  assign sck_fall = ~sck_s & sck_prev;

  // ---------------------------------------------------------------------------
  // Byte assembly
  // ---------------------------------------------------------------------------
  logic [2:0] bit_cnt;
  logic [6:0] shift_in;   // the first seven bits of the byte in progress
  logic [7:0] rx_byte;    // complete byte, valid while byte_done is high
  logic       byte_done;

  assign rx_byte   = {shift_in, din_s};
  assign byte_done = ~cs_s & (state_q != ST_IDLE) & sck_rise & (bit_cnt == 3'd7);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (cs_s) begin
      // Deselect ends the transaction in any state. A partial byte is dropped.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_CMD;
        ST_CMD:  if (byte_done) state_d = rx_byte[7] ? ST_WRITE : ST_READ;
        default: state_d = state_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: strobes, address and read shift register
  // ---------------------------------------------------------------------------
  logic       rd_cap;     // reg_rdata is valid this cycle
  logic [7:0] tx_shift;
  logic       dout_q;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      bit_cnt   <= 3'd0;
      shift_in  <= 7'd0;
      reg_addr  <= 7'd0;
      reg_wdata <= 8'd0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      rd_cap    <= 1'b0;
      tx_shift  <= 8'd0;
      dout_q    <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      reg_re <= 1'b0;
      rd_cap <= reg_re;

      // Post-write address increment, one cycle after the strobe.
      if (reg_we) reg_addr <= reg_addr + 7'd1;

      if (state_q == ST_IDLE || cs_s) begin
        bit_cnt  <= 3'd0;
        shift_in <= 7'd0;
      end else if (sck_rise) begin
        bit_cnt <= bit_cnt + 3'd1;   // wraps 7 -> 0 on the byte's last bit
        if (state_q != ST_READ) shift_in <= {shift_in[5:0], din_s};
      end

      if (byte_done) begin
        case (state_q)
          ST_CMD: begin
            reg_addr <= rx_byte[6:0];
            reg_re   <= ~rx_byte[7];
          end
          ST_WRITE: begin
            reg_wdata <= rx_byte;
            reg_we    <= 1'b1;
          end
          ST_READ: begin
            // Prefetch for the next byte, so the address moves first.
            reg_addr <= reg_addr + 7'd1;
            reg_re   <= 1'b1;
          end
          default: ;
        endcase
      end

      // Each sck fall presents the next bit. The shift register MSB moves to
      // the output flop on the fall. A freshly loaded byte therefore appears
      // bit7-first on the fall that follows the load.
      if (state_q != ST_READ) begin
        tx_shift <= 8'd0;
        dout_q   <= 1'b0;
      end else if (rd_cap) begin
        tx_shift <= reg_rdata;
      end else if (sck_fall) begin
        dout_q   <= tx_shift[7];
        tx_shift <= {tx_shift[6:0], 1'b0};
      end
    end
  end

  assign spi_dout    = dout_q & (state_q == ST_READ);
  assign spi_dout_oe = ~cs_s;

endmodule

// File: tb/tb_silife_spi_ctrl.sv
module tb_silife_spi_ctrl;

  localparam int SYNC = 2;
  localparam int HMIN = SYNC + 2;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic       clock = 1'b0;
  logic       resetb = 1'b0;
  logic       spi_cs = 1'b1;
  logic       spi_sck = 1'b0;
  logic       spi_din = 1'b0;
  logic       spi_dout;
  logic       spi_dout_oe;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata = 8'h00;

  always #5 clock = ~clock;

  silife_spi_ctrl #(.SYNC_STAGES(SYNC)) dut (
    .clock       (clock),
    .resetb      (resetb),
    .spi_cs      (spi_cs),
    .spi_sck     (spi_sck),
    .spi_din     (spi_din),
    .spi_dout    (spi_dout),
    .spi_dout_oe (spi_dout_oe),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_we      (reg_we),
    .reg_re      (reg_re),
    .reg_rdata   (reg_rdata)
  );

  // ---------------------------------------------------------------------------
  // Register bank attached to the DUT. An unwritten location reads addr ^ 0xA5.
  // ---------------------------------------------------------------------------
  logic [7:0]   bank [128];
  logic [127:0] written = '0;

  always @(posedge clock) begin
    if (reg_we) begin
      bank[reg_addr]    <= reg_wdata;
      written[reg_addr] <= 1'b1;
    end
    if (reg_re) reg_rdata <= written[reg_addr] ? bank[reg_addr] : ({1'b0, reg_addr} ^ 8'hA5);
  end

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard state
  // ---------------------------------------------------------------------------
  int          checks = 0;
  int          failures = 0;
  logic [14:0] exp_q[$];       // expected write strobes {addr, data}
  logic [6:0]  exp_re_q[$];    // expected read strobe addresses
  logic [7:0]  ref_mem [128];  // register contents the transactions imply
  logic [7:0]  wbuf [4];
  logic [7:0]  rbuf [4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Strobe monitor: every strobe must match the head of its expected queue.
  always @(negedge clock) begin
    logic [14:0] e;
    logic [6:0]  ea;
    if (resetb) begin
      if (reg_we || reg_re) begin
        checks++;
        assert (!(reg_we && reg_re)) else begin
          failures++;
          $error("FAIL strobe_overlap we=%0b re=%0b exp=exclusive", reg_we, reg_re);
        end
      end
      if (reg_we) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          failures++;
          $error("FAIL unexpected_we addr=0x%0h data=0x%0h exp=none", reg_addr, reg_wdata);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          checks++;
          assert ({reg_addr, reg_wdata} === e) else begin
            failures++;
            $error("FAIL we_strobe got addr=0x%0h data=0x%0h exp addr=0x%0h data=0x%0h",
                   reg_addr, reg_wdata, e[14:8], e[7:0]);
          end
        end
      end
      if (reg_re) begin
        checks++;
        assert (exp_re_q.size() != 0) else begin
          failures++;
          $error("FAIL unexpected_re addr=0x%0h exp=none", reg_addr);
        end
        if (exp_re_q.size() != 0) begin
          ea = exp_re_q.pop_front();
          checks++;
          assert (reg_addr === ea) else begin
            failures++;
            $error("FAIL re_strobe got addr=0x%0h exp addr=0x%0h", reg_addr, ea);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (all inputs change on the falling clock edge)
  // ---------------------------------------------------------------------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Mode 0: din changes while sck is low. MISO is sampled just before sck rises.
  task automatic spi_xfer(input logic [7:0] tx, input int nbits, input int half,
                          output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_din = tx[7-i];
      wait_clk(half);
      rx = {rx[6:0], spi_dout};
      spi_sck = 1'b1;
      wait_clk(half);
      spi_sck = 1'b0;
    end
  endtask

  task automatic cs_low(input int half);
    spi_cs = 1'b0;
    wait_clk(half);
    chk("oe_selected", spi_dout_oe, 1);
  endtask

  task automatic cs_high(input int half);
    wait_clk(half);
    spi_cs = 1'b1;
    wait_clk(half + 2 * SYNC + 4);
    chk("oe_idle", spi_dout_oe, 0);
    chk("dout_idle", spi_dout, 0);
    chk("we_drained", exp_q.size(), 0);
    chk("re_drained", exp_re_q.size(), 0);
  endtask

  task automatic do_write(input logic [6:0] a, input int n, input int half);
    logic [7:0] rx;
    logic [6:0] ak;
    cs_low(half);
    spi_xfer({1'b1, a}, 8, half, rx);
    for (int k = 0; k < n; k++) begin
      ak = a + 7'(k);
      exp_q.push_back({ak, wbuf[k]});
      spi_xfer(wbuf[k], 8, half, rx);
      ref_mem[ak] = wbuf[k];
    end
    cs_high(half);
  endtask

  task automatic do_read(input logic [6:0] a, input int n, input int half);
    logic [7:0] rx;
    logic [6:0] ak;
    exp_re_q.push_back(a);
    cs_low(half);
    spi_xfer({1'b0, a}, 8, half, rx);
    for (int k = 0; k < n; k++) begin
      ak = a + 7'(k);
      exp_re_q.push_back(ak + 7'd1);
      spi_xfer(8'($urandom), 8, half, rx);   // din is ignored in the data phase
      rbuf[k] = rx;
      chk("rd_byte", rx, ref_mem[ak]);
    end
    cs_high(half);
  endtask

  // ---------------------------------------------------------------------------
  // Directed and random sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [7:0] rx;
    logic [6:0] ra;
    int         rn;
    int         rh;

    for (int i = 0; i < 128; i++) ref_mem[i] = 8'(i) ^ 8'hA5;

    // Reset state
    resetb = 1'b0;
    wait_clk(4);
    chk("rst_dout", spi_dout, 0);
    chk("rst_oe", spi_dout_oe, 0);
    chk("rst_addr", reg_addr, 0);
    chk("rst_wdata", reg_wdata, 0);
    chk("rst_we", reg_we, 0);
    chk("rst_re", reg_re, 0);
    resetb = 1'b1;
    wait_clk(6);
    chk("idle_oe", spi_dout_oe, 0);

    // Burst read from 0x05: two data bytes, three read strobes
    do_read(7'h05, 2, HMIN);
    chk("burst_rd0", rbuf[0], 8'hA0);
    chk("burst_rd1", rbuf[1], 8'hA3);

    // Single write at minimum, medium and slow sck
    wbuf[0] = 8'h3C;
    do_write(7'h05, 1, HMIN);
    do_write(7'h05, 1, 6);
    do_write(7'h05, 1, 50);

    // Burst write wrapping 0x7F -> 0x00
    wbuf[0] = 8'h11;
    wbuf[1] = 8'h22;
    do_write(7'h7F, 2, HMIN);

    // Command-only write produces no strobe
    do_write(7'h10, 0, HMIN);

    // Aborted write: partial data byte, then deselect
    cs_low(HMIN);
    spi_xfer(8'h82, 8, HMIN, rx);
    spi_xfer(8'h55, 4, HMIN, rx);
    cs_high(HMIN);
    wbuf[0] = 8'h55;
    do_write(7'h02, 1, HMIN);

    // Read back the wrapped burst and the recovered write
    do_read(7'h7F, 2, HMIN);
    chk("wrap_rd0", rbuf[0], 8'h11);
    chk("wrap_rd1", rbuf[1], 8'h22);
    do_read(7'h02, 1, 5);
    chk("abort_rd", rbuf[0], 8'h55);

    // Reset during the second byte of a read
    exp_re_q.push_back(7'h40);
    cs_low(HMIN);
    spi_xfer(8'h40, 8, HMIN, rx);
    exp_re_q.push_back(7'h41);
    spi_xfer(8'h00, 8, HMIN, rx);
    chk("rst_rd_b0", rx, ref_mem[7'h40]);
    spi_xfer(8'h00, 3, HMIN, rx);
    chk("rst_rd_part", rx[2:0], ref_mem[7'h41][7:5]);
    wait_clk(HMIN);
    chk("pre_rst_dout", spi_dout, ref_mem[7'h41][4]);
    chk("pre_rst_addr", reg_addr, 7'h41);
    resetb = 1'b0;
    #1;
    chk("midrst_dout", spi_dout, 0);
    chk("midrst_oe", spi_dout_oe, 0);
    chk("midrst_re", reg_re, 0);
    chk("midrst_we", reg_we, 0);
    chk("midrst_addr", reg_addr, 0);
    spi_cs = 1'b1;
    spi_sck = 1'b0;
    wait_clk(4);
    resetb = 1'b1;
    wait_clk(10);
    chk("postrst_re_q", exp_re_q.size(), 0);
    chk("postrst_oe", spi_dout_oe, 0);

    // Normal operation after reset release
    wbuf[0] = 8'h9D;
    wbuf[1] = 8'h4E;
    do_write(7'h41, 2, HMIN);
    do_read(7'h40, 3, HMIN);

    // Random transactions against the reference memory
    for (int t = 0; t < 20; t++) begin
      ra = 7'($urandom_range(0, 127));
      rn = $urandom_range(0, 3);
      rh = $urandom_range(HMIN, HMIN + 4);
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 4; k++) wbuf[k] = 8'($urandom);
        do_write(ra, rn, rh);
      end else begin
        do_read(ra, rn, rh);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog bound on the whole run
  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/silife_spi_ctrl.md
Name: silife_spi_ctrl

Overview:
- Chip-level SPI control slave for the Game-of-Life user project.
- Pins: cs on mprj_io[22], sck on mprj_io[23], din on mprj_io[24], dout on mprj_io[25].
- Oversamples the external SPI pins with the system clock and converts byte transactions into single-cycle register read/write strobes toward the grid/display register file.
- Sits between the user-area GPIO pads and the core's register bank.

Parameters:
- SYNC_STAGES, 2, number of flops in each input synchronizer for cs/sck/din (minimum 2).

Ports:
- clock  input  1  system clock; all logic on rising edge.
- resetb  input  1  reset, asynchronous and active-low.
- spi_cs  input  1  chip select, active-low, asynchronous to clock.
- spi_sck  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clock.
- spi_din  input  1  MOSI, MSB first.
- spi_dout  output  1  MISO, MSB first.
- spi_dout_oe  output  1  pad output enable; 1 while the synchronized cs is low.
- reg_addr  output  7  register address for read/write strobes.
- reg_wdata  output  8  write data.
- reg_we  output  1  one-cycle write strobe.
- reg_re  output  1  one-cycle read strobe.
- reg_rdata  input  8  read data; must be valid on the cycle after reg_re.

Behaviour:
- Reset (resetb=0, asynchronous): state=IDLE; all outputs 0; bit counter 0; synchronizers cleared to cs=1, sck=0, din=0.
- Input handling:
  - cs, sck and din each pass through a SYNC_STAGES-flop synchronizer.
  - sck rise/fall events come from comparing the synchronized value with its previous value.
- Timing requirement on the master: sck high and low phases each last at least SYNC_STAGES+2 clock cycles; cs setup/hold to sck of at least that long.
- States:
  - IDLE: synchronized cs high.
  - CMD: first byte of a transaction.
  - WRITE: data phase of a write transaction.
  - READ: data phase of a read transaction.
- Transitions:
  - IDLE -> CMD when cs falls; bit counter cleared.
  - In any state, cs high -> IDLE immediately. Any partial byte is discarded; no strobe is issued.
- Sampling:
  - din is sampled on each sck rise event and shifted in MSB first.
  - The 8th rise completes a byte; the bit counter wraps 7 -> 0.
- Command byte: bit7=1 means write, 0 means read; bits6:0 = start address, loaded into reg_addr.
- CMD completion:
  - Write -> WRITE.
  - Read -> READ, and reg_re pulses for one cycle on the cycle after the 8th rise.
  - reg_rdata is captured into the output shift register on the following cycle.
- WRITE data bytes:
  - On each completed byte, reg_wdata = byte and reg_we pulses for one cycle with the current reg_addr.
  - On the next cycle, reg_addr increments modulo 128 (0x7F -> 0x00).
- READ data bytes:
  - spi_dout presents the shift register MSB.
  - The shift register shifts left on each sck fall event. The first fall after the command byte's 8th rise presents bit7 of the first data byte.
  - On each data byte's 8th rise: reg_addr increments modulo 128, then reg_re pulses and the new reg_rdata is captured (prefetch for the next byte).
  - din is ignored during READ.
- spi_dout is 0 in IDLE, CMD and WRITE.
- reg_we and reg_re are never both high in the same cycle.
- Reset asserted mid-transaction: everything returns to reset values at once; no pending strobe fires after reset is released.
- A transaction of only a command byte, or with zero data bytes, produces no reg_we.

Test Plan:
- Single write: cs low, send 0x85, 0x3C, cs high -> exactly one reg_we pulse with reg_addr=0x05, reg_wdata=0x3C; reg_re never asserted.
- Burst write with wrap: send 0xFF, 0x11, 0x22 -> reg_we at addr 0x7F with 0x11, then at addr 0x00 with 0x22.
- Burst read: send 0x05, then clock 16 sck cycles; bench drives reg_rdata = reg_addr ^ 0xA5 -> spi_dout bytes 0xA0 then 0xA3; reg_re pulses at addr 0x05, 0x06, 0x07.
- Aborted write: send 0x82, then 4 data bits, then cs high -> no reg_we. A following transaction 0x82, 0x55 writes 0x55 to addr 0x02.
- Reset mid-read: pull resetb low during the second read byte -> spi_dout, spi_dout_oe, reg_re, reg_we and reg_addr all 0 within the same cycle. A new transaction after release works normally.
- Slow/fast sck: repeat the single write with sck half-period = SYNC_STAGES+2 clocks and with 50 clocks -> identical strobes.
